// File: rtl/fetch_queue.sv
// Decode-side instruction queue: compacts up to two fetched slots per cycle into a
// circular buffer and presents the two oldest entries to decode in program order.
module fetch_queue #(
    parameter int XLEN    = 32,
    parameter int FETCH_W = 2,
    parameter int DEPTH   = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [FETCH_W-1:0]         if_valid,
    input  logic [XLEN-1:0]            if_pc    [FETCH_W],
    input  logic [XLEN-1:0]            if_instr [FETCH_W],
    input  logic                       flush,
    input  logic                       dec_ready,
    output logic [FETCH_W-1:0]         dq_valid,
    output logic [XLEN-1:0]            dq_pc    [FETCH_W],
    output logic [XLEN-1:0]            dq_instr [FETCH_W],
    output logic                       stall,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic                       overflow_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] mem_pc_q    [DEPTH];
    logic [XLEN-1:0] mem_instr_q [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          stall_q, stall_d;
    logic          overflow_q, overflow_d;

    logic [PW-1:0] head_plus1;
    logic [PW-1:0] tail_plus1;
    logic [1:0]    pop;
    logic [1:0]    push_raw;
    logic [1:0]    push;
    logic [CW-1:0] free;
    logic          fits;
    logic          we0;
    logic          we1;
    logic [XLEN-1:0] wr0_pc;
    logic [XLEN-1:0] wr0_instr;

    assign head_plus1 = head_q + PW'(1);
    assign tail_plus1 = tail_q + PW'(1);

    always_comb begin
        pop        = 2'd0;
        push_raw   = {1'b0, if_valid[0]} + {1'b0, if_valid[1]};
        free       = '0;
        fits       = 1'b0;
        push       = 2'd0;
        we0        = 1'b0;
        we1        = 1'b0;
        wr0_pc     = if_pc[0];
        wr0_instr  = if_instr[0];
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (dec_ready) begin
            if (count_q >= CW'(2)) begin
                pop = 2'd2;
            end else if (count_q == CW'(1)) begin
                pop = 2'd1;
            end
        end

        // Room freed by this cycle's dequeue is usable by this cycle's enqueue.
        free = CW'(DEPTH) - count_q + CW'(pop);
        fits = CW'(push_raw) <= free;
        push = fits ? push_raw : 2'd0;

        // Compaction: a lone slot-1 instruction lands at tail, leaving no hole.
        if (!if_valid[0]) begin
            wr0_pc    = if_pc[1];
            wr0_instr = if_instr[1];
        end

        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            we0        = push != 2'd0;
            we1        = push == 2'd2;
            head_d     = head_q + PW'(pop);
            tail_d     = tail_q + PW'(push);
            count_d    = count_q + CW'(push) - CW'(pop);
            overflow_d = overflow_q | !fits;
        end

        // Leaves space for the bundle already in flight plus the current one.
        stall_d = count_d > CW'(DEPTH - 2 * FETCH_W);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            stall_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            stall_q    <= stall_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we0) begin
            mem_pc_q[tail_q]    <= wr0_pc;
            mem_instr_q[tail_q] <= wr0_instr;
        end
        if (we1) begin
            mem_pc_q[tail_plus1]    <= if_pc[1];
            mem_instr_q[tail_plus1] <= if_instr[1];
        end
    end

    assign dq_valid[0]  = count_q != '0;
    assign dq_valid[1]  = count_q >= CW'(2);
    assign dq_pc[0]     = mem_pc_q[head_q];
    assign dq_pc[1]     = mem_pc_q[head_plus1];
    assign dq_instr[0]  = mem_instr_q[head_q];
    assign dq_instr[1]  = mem_instr_q[head_plus1];
    assign stall        = stall_q;
    assign occupancy    = count_q;
    assign overflow_err = overflow_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios followed by randomized traffic,
// all compared against a queue-based reference model of the buffering rules.
module tb_fetch_queue;

    localparam int XLEN  = 32;
    localparam int FW    = 2;
    localparam int DEPTH = 8;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic              clk;
    logic              reset;
    logic [FW-1:0]     if_valid;
    logic [XLEN-1:0]   if_pc    [FW];
    logic [XLEN-1:0]   if_instr [FW];
    logic              flush;
    logic              dec_ready;
    logic [FW-1:0]     dq_valid;
    logic [XLEN-1:0]   dq_pc    [FW];
    logic [XLEN-1:0]   dq_instr [FW];
    logic              stall;
    logic [3:0]        occupancy;
    logic              overflow_err;

    fetch_queue #(.XLEN(XLEN), .FETCH_W(FW), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .if_valid     (if_valid),
        .if_pc        (if_pc),
        .if_instr     (if_instr),
        .flush        (flush),
        .dec_ready    (dec_ready),
        .dq_valid     (dq_valid),
        .dq_pc        (dq_pc),
        .dq_instr     (dq_instr),
        .stall        (stall),
        .occupancy    (occupancy),
        .overflow_err (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: contents in program order, plus the two status bits.
    ent_t mq[$];
    logic m_stall;
    logic m_ovf;

    int checks = 0;
    int passes = 0;
    logic [31:0] next_pc = 32'h100;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic modelEdge(input logic [1:0] v, input ent_t s0, input ent_t s1,
                             input logic fl, input logic dr);
        int   popn;
        ent_t inq[$];
        if (fl) begin
            mq.delete();
            m_stall = 1'b0;
        end else begin
            popn = dr ? ((mq.size() >= 2) ? 2 : mq.size()) : 0;
            if (v[0]) inq.push_back(s0);
            if (v[1]) inq.push_back(s1);
            if (inq.size() > DEPTH - mq.size() + popn) begin
                m_ovf = 1'b1;
            end else begin
                repeat (popn) void'(mq.pop_front());
                foreach (inq[i]) mq.push_back(inq[i]);
            end
            m_stall = mq.size() > DEPTH - 2 * FW;
        end
    endtask

    task automatic compareAll();
        checkOutput("occupancy", 32'(occupancy), 32'(mq.size()));
        checkOutput("dq_valid0", 32'(dq_valid[0]), 32'(mq.size() >= 1));
        checkOutput("dq_valid1", 32'(dq_valid[1]), 32'(mq.size() >= 2));
        checkOutput("stall", 32'(stall), 32'(m_stall));
        checkOutput("overflow_err", 32'(overflow_err), 32'(m_ovf));
        if (mq.size() >= 1) begin
            checkOutput("dq_pc0", dq_pc[0], mq[0].pc);
            checkOutput("dq_instr0", dq_instr[0], mq[0].instr);
        end
        if (mq.size() >= 2) begin
            checkOutput("dq_pc1", dq_pc[1], mq[1].pc);
            checkOutput("dq_instr1", dq_instr[1], mq[1].instr);
        end
    endtask

    // Drive one cycle of inputs from a negedge, advance the model at the posedge,
    // then compare at the following negedge.
    task automatic applyStimulus(input logic [1:0] v,
                                 input logic [31:0] pc0, input logic [31:0] in0,
                                 input logic [31:0] pc1, input logic [31:0] in1,
                                 input logic fl, input logic dr);
        ent_t s0;
        ent_t s1;
        s0.pc = pc0; s0.instr = in0;
        s1.pc = pc1; s1.instr = in1;
        if_valid    = v;
        if_pc[0]    = pc0;
        if_instr[0] = in0;
        if_pc[1]    = pc1;
        if_instr[1] = in1;
        flush       = fl;
        dec_ready   = dr;
        @(posedge clk);
        modelEdge(v, s0, s1, fl, dr);
        @(negedge clk);
        compareAll();
    endtask

    task automatic pushPair(input logic [31:0] pc, input logic dr);
        applyStimulus(2'b11, pc, ~pc, pc + 32'h4, pc ^ 32'h5A5A0000, 1'b0, dr);
    endtask

    task automatic idle(input logic dr);
        applyStimulus(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, dr);
    endtask

    initial begin
        logic [1:0] rv;
        logic       rf;
        logic       rd;

        reset = 1'b1;
        if_valid = '0;
        if_pc[0] = '0; if_pc[1] = '0;
        if_instr[0] = '0; if_instr[1] = '0;
        flush = 1'b0;
        dec_ready = 1'b0;
        m_stall = 1'b0;
        m_ovf = 1'b0;

        repeat (2) @(negedge clk);
        compareAll();
        reset = 1'b0;

        // Basic pair enqueue
        applyStimulus(2'b11, 32'h00, 32'h11111111, 32'h04, 32'h22222222, 1'b0, 1'b0);
        checkOutput("t1_occ", 32'(occupancy), 32'd2);
        checkOutput("t1_valid", 32'(dq_valid), 32'h3);
        checkOutput("t1_pc0", dq_pc[0], 32'h00);
        checkOutput("t1_pc1", dq_pc[1], 32'h04);

        // Fill toward full, watch stall rise, then overflow
        pushPair(32'h08, 1'b0);
        checkOutput("t2_occ4", 32'(occupancy), 32'd4);
        checkOutput("t2_stall_lo", 32'(stall), 32'd0);
        pushPair(32'h10, 1'b0);
        checkOutput("t2_occ6", 32'(occupancy), 32'd6);
        checkOutput("t2_stall_hi", 32'(stall), 32'd1);
        pushPair(32'h18, 1'b0);
        checkOutput("t2_occ8", 32'(occupancy), 32'd8);
        pushPair(32'h20, 1'b0);
        checkOutput("t2_occ_drop", 32'(occupancy), 32'd8);
        checkOutput("t2_ovf", 32'(overflow_err), 32'd1);
        checkOutput("t2_head", dq_pc[0], 32'h00);
        repeat (4) idle(1'b1);
        checkOutput("t2_drained", 32'(occupancy), 32'd0);

        // Compaction of partial bundles
        applyStimulus(2'b10, 32'hDEAD, 32'hDEADBEEF, 32'h0C, 32'hC0C0C0C0, 1'b0, 1'b0);
        applyStimulus(2'b01, 32'h10, 32'h10101010, 32'hBEEF, 32'hBEEFBEEF, 1'b0, 1'b0);
        checkOutput("t3_occ", 32'(occupancy), 32'd2);
        checkOutput("t3_pc0", dq_pc[0], 32'h0C);
        checkOutput("t3_pc1", dq_pc[1], 32'h10);
        checkOutput("t3_instr0", dq_instr[0], 32'hC0C0C0C0);

        // Concurrent push/pop across pointer wrap
        applyStimulus(2'b01, 32'h14, 32'h14141414, 32'h0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            pushPair(32'h200 + 32'(i) * 32'h8, 1'b1);
            checkOutput("t4_occ", 32'(occupancy), 32'd3);
        end

        // Flush beats a simultaneous enqueue
        applyStimulus(2'b01, 32'h300, 32'h3, 32'h0, 32'h0, 1'b0, 1'b0);
        pushPair(32'h304, 1'b0);
        checkOutput("t5_occ6", 32'(occupancy), 32'd6);
        applyStimulus(2'b11, 32'h400, 32'h4, 32'h404, 32'h5, 1'b1, 1'b1);
        checkOutput("t5_occ0", 32'(occupancy), 32'd0);
        checkOutput("t5_valid", 32'(dq_valid), 32'd0);
        checkOutput("t5_stall", 32'(stall), 32'd0);
        checkOutput("t5_ovf_kept", 32'(overflow_err), 32'd1);
        applyStimulus(2'b01, 32'h08, 32'h88888888, 32'h0, 32'h0, 1'b0, 1'b0);
        checkOutput("t5_pc0", dq_pc[0], 32'h08);

        // Asynchronous reset between edges
        pushPair(32'h500, 1'b0);
        pushPair(32'h508, 1'b0);
        checkOutput("t6_occ5", 32'(occupancy), 32'd5);
        checkOutput("t6_stall", 32'(stall), 32'd1);
        #2 reset = 1'b1;
        #1;
        checkOutput("t6_valid", 32'(dq_valid), 32'd0);
        checkOutput("t6_stall_clr", 32'(stall), 32'd0);
        checkOutput("t6_occ_clr", 32'(occupancy), 32'd0);
        checkOutput("t6_ovf_clr", 32'(overflow_err), 32'd0);
        mq.delete();
        m_stall = 1'b0;
        m_ovf = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        compareAll();

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            rv = 2'($urandom_range(0, 3));
            rf = ($urandom_range(0, 24) == 0);
            rd = (n % 100 < 50) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            applyStimulus(rv, next_pc, $urandom, next_pc + 32'h4, $urandom, rf, rd);
            next_pc = next_pc + 32'h8;
        end

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
